// File: rtl/control_module_sequencer_pkg.sv
// Shared types and codes for the LED control-module sequencer.
package control_module_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PAUSE   = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_MANUAL  = 2'b11;

  // Both auto modes step on the divided tick.
  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/control_module_sequencer_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-cycle debounce,
// one-cycle pulse on each accepted rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 27
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic BTN_PULSE
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw button into the CLOCK domain.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= BTN_RAW;
      r_sync1 <= r_sync0;
    end
  end

  // Flip the filtered level after DEBOUNCE_CYCLES consecutive mismatching cycles;
  // any agreeing cycle restarts the count. Pulse is raised with the rising flip.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (r_sync1 != r_level) begin
        if (r_cnt == LP_LAST) begin
          r_level <= r_sync1;
          r_pulse <= r_sync1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign BTN_LEVEL = r_level;
  assign BTN_PULSE = r_pulse;

endmodule

// File: rtl/control_module_sequencer.sv
// Steps the A/B inputs of the LED control module through codes 00..11, either on a
// divided tick or per debounced button press, and latches the returned LEDs.
module control_module_sequencer
  import control_module_sequencer_pkg::*;
#(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 27
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       BTN_START,
  input  logic       BTN_STEP,
  input  logic [1:0] MODE,
  input  logic [2:0] LED_IN,
  output logic       A,
  output logic       B,
  output logic [1:0] PHASE,
  output logic [2:0] LED_LATCH,
  output logic       BUSY,
  output logic       SWEEP_DONE
);

  localparam logic [CNT_W-1:0] LP_TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  logic [1:0]       r_phase;
  logic [2:0]       r_led_latch;
  logic             r_busy;
  logic             r_sweep_done;
  logic [CNT_W-1:0] r_tick_cnt;

  logic w_start_p;
  logic w_step_p;
  // Only the edges drive the sequencer; the filtered levels are not needed here.
  logic w_start_level_unused;
  logic w_step_level_unused;
  logic w_auto;
  logic w_tick;
  logic w_advance;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start_db (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .BTN_RAW   (BTN_START),
    .BTN_LEVEL (w_start_level_unused),
    .BTN_PULSE (w_start_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step_db (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .BTN_RAW   (BTN_STEP),
    .BTN_LEVEL (w_step_level_unused),
    .BTN_PULSE (w_step_p)
  );

  assign w_auto    = is_auto(MODE);
  assign w_tick    = (r_tick_cnt == LP_TICK_LAST);
  // Manual steps count only in RUN; the SAMPLE branch never looks at w_advance.
  assign w_advance = (w_auto && w_tick) || ((MODE == MODE_MANUAL) && w_step_p);

  // Sequencer FSM with its tick counter and all registered outputs.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_phase      <= 2'd0;
      r_led_latch  <= 3'd0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_tick_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_p && (MODE != MODE_PAUSE)) begin
            r_state    <= ST_SAMPLE;
            r_phase    <= 2'd0;
            r_tick_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          // MODE=00 or manual leaves the partial count untouched.
          if (w_auto) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
          if (w_start_p) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
            r_busy  <= 1'b0;
          end else if (w_advance) begin
            if ((MODE == MODE_ONESHOT) && (r_phase == 2'd3)) begin
              r_state      <= ST_DONE;
              r_phase      <= 2'd0;
              r_busy       <= 1'b0;
              r_sweep_done <= 1'b1;
            end else begin
              r_state <= ST_SAMPLE;
              r_phase <= r_phase + 2'd1;
            end
          end
        end
        ST_SAMPLE: begin
          if (w_auto) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
          // An abort here drops the pending latch update.
          if (w_start_p) begin
            r_state <= ST_IDLE;
            r_phase <= 2'd0;
            r_busy  <= 1'b0;
          end else begin
            r_led_latch <= LED_IN;
            r_state     <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (MODE == MODE_PAUSE) begin
            r_state      <= ST_IDLE;
            r_sweep_done <= 1'b0;
          end else if (w_start_p) begin
            r_state      <= ST_SAMPLE;
            r_phase      <= 2'd0;
            r_tick_cnt   <= '0;
            r_busy       <= 1'b1;
            r_sweep_done <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign A          = r_phase[1];
  assign B          = r_phase[0];
  assign PHASE      = r_phase;
  assign LED_LATCH  = r_led_latch;
  assign BUSY       = r_busy;
  assign SWEEP_DONE = r_sweep_done;

endmodule

// File: tb/tb_control_module_sequencer.sv
// Directed + randomized bench for control_module_sequencer (TICK_DIV=4, DEBOUNCE_CYCLES=3).
// Expected codes come from elapsed-cycle arithmetic and press counting; LED_IN comes
// from a behavioural model of the control module.
module tb_control_module_sequencer;
  import control_module_sequencer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int CNT_W    = 8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_START = 1'b0;
  logic       BTN_STEP = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [2:0] LED_IN;
  logic       A, B, BUSY, SWEEP_DONE;
  logic [1:0] PHASE;
  logic [2:0] LED_LATCH;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int s_cyc = 0;
  int k = 0;
  int h = 0;
  int exp_ph = 0;

  control_module_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .BTN_START(BTN_START), .BTN_STEP(BTN_STEP), .MODE(MODE),
    .LED_IN(LED_IN), .A(A), .B(B), .PHASE(PHASE), .LED_LATCH(LED_LATCH), .BUSY(BUSY),
    .SWEEP_DONE(SWEEP_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  // Control module truth table: {LED3,LED2,LED1} = {A^B, A|B, A&B}.
  function automatic logic [2:0] led_model(input logic [1:0] code);
    return {code[1] ^ code[0], code[1] | code[0], code[1] & code[0]};
  endfunction

  assign LED_IN = led_model({A, B});

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] ph, input logic busy, input logic done);
    chk({tag, ".phase"}, 8'(PHASE), 8'(ph));
    chk({tag, ".ab"},    8'({A, B}), 8'(ph));
    chk({tag, ".busy"},  8'(BUSY), 8'(busy));
    chk({tag, ".done"},  8'(SWEEP_DONE), 8'(done));
  endtask

  task automatic chk_led(input string tag, input logic [1:0] code);
    chk({tag, ".led"}, 8'(LED_LATCH), 8'(led_model(code)));
  endtask

  // Advance n clock edges; land 1 ns after the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
      cyc++;
    end
  endtask

  task automatic press(input bit is_step, input int hold);
    if (is_step) BTN_STEP = 1'b1;
    else         BTN_START = 1'b1;
    tick(hold);
    BTN_STEP  = 1'b0;
    BTN_START = 1'b0;
  endtask

  // A clean start press is accepted on the 6th edge after it is raised.
  task automatic start_sweep();
    press(1'b0, 5);
    tick(1);
    s_cyc = cyc;
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_state("rst", 2'd0, 1'b0, 1'b0);
    chk_led("rst", 2'd0);
    #2 RESET = 1'b0;
    tick(5);
    chk_state("idle", 2'd0, 1'b0, 1'b0);

    // Auto continuous: each code held TICK_DIV cycles
    MODE = MODE_AUTO;
    start_sweep();
    chk_state("auto.k0", 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) begin
      tick();
      k = cyc - s_cyc;
      chk_state("auto", 2'((k / TICK_DIV) % 4), 1'b1, 1'b0);
      if (k % TICK_DIV != 0) chk_led("auto", 2'((k / TICK_DIV) % 4));
    end

    // Abort landing on the same edge as a tick (k=28)
    tick(22 - (cyc - s_cyc));
    press(1'b0, 5);
    tick(1);
    chk_state("abort", 2'd0, 1'b0, 1'b0);
    chk_led("abort", 2'd2);
    tick(12);
    chk_state("abort.idle", 2'd0, 1'b0, 1'b0);

    // One-shot, twice (second start from DONE)
    MODE = MODE_ONESHOT;
    for (int sw = 0; sw < 2; sw++) begin
      start_sweep();
      chk_state("os.k0", 2'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 16; i++) begin
        tick();
        k = cyc - s_cyc;
        if (k < 16) chk_state("os", 2'(k / TICK_DIV), 1'b1, 1'b0);
      end
      chk_state("os.done", 2'd0, 1'b0, 1'b1);
      chk_led("os.done", 2'd3);
      tick(6);
      chk_state("os.hold", 2'd0, 1'b0, 1'b1);
    end
    MODE = MODE_PAUSE;
    tick();
    chk_state("os.idle", 2'd0, 1'b0, 1'b0);
    press(1'b0, 5);
    tick(8);
    chk_state("pause.nostart", 2'd0, 1'b0, 1'b0);

    // Pause mid-step, then resume with the partial count kept
    MODE = MODE_AUTO;
    start_sweep();
    tick(2);
    MODE = MODE_PAUSE;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("pause.frozen", 8'(PHASE), 8'd0);
    end
    MODE = MODE_AUTO;
    tick();
    chk_state("pause.res1", 2'd0, 1'b1, 1'b0);
    tick();
    chk_state("pause.res2", 2'd1, 1'b1, 1'b0);
    tick();
    chk_led("pause.res", 2'd1);
    press(1'b0, 5);
    tick(8);
    chk_state("pause.abort", 2'd0, 1'b0, 1'b0);

    // Manual stepping and debounce
    MODE = MODE_MANUAL;
    start_sweep();
    chk_state("man.k0", 2'd0, 1'b1, 1'b0);
    tick();
    chk_led("man.k1", 2'd0);
    press(1'b1, 2);
    tick(10);
    chk_state("man.glitch", 2'd0, 1'b1, 1'b0);
    press(1'b1, 5);
    tick(10);
    chk_state("man.press5", 2'd1, 1'b1, 1'b0);
    press(1'b1, 50);
    tick(10);
    chk_state("man.press50", 2'd2, 1'b1, 1'b0);
    chk_led("man.press50", 2'd2);

    // Random press lengths: a press counts iff held >= DEB cycles
    exp_ph = 2;
    for (int i = 0; i < 12; i++) begin
      h = int'($urandom_range(1, 8));
      press(1'b1, h);
      tick(8);
      if (h >= DEB) exp_ph = (exp_ph + 1) % 4;
      chk_state("man.rand", 2'(exp_ph), 1'b1, 1'b0);
      chk_led("man.rand", 2'(exp_ph));
    end
    press(1'b0, 5);
    tick(8);
    chk_state("man.abort", 2'd0, 1'b0, 1'b0);

    // Random waits in auto mode, then async reset at PHASE=2
    MODE = MODE_AUTO;
    start_sweep();
    for (int i = 0; i < 4; i++) begin
      tick(int'($urandom_range(1, 10)));
      k = cyc - s_cyc;
      chk_state("auto.rand", 2'((k / TICK_DIV) % 4), 1'b1, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      if (((cyc - s_cyc) / TICK_DIV) % 4 == 2) break;
      tick();
    end
    chk_state("rst.pre", 2'd2, 1'b1, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk_state("rst.mid", 2'd0, 1'b0, 1'b0);
    chk_led("rst.mid", 2'd0);
    #2 RESET = 1'b0;
    tick(20);
    chk_state("rst.after", 2'd0, 1'b0, 1'b0);
    start_sweep();
    chk_state("rst.restart", 2'd0, 1'b1, 1'b0);
    tick(TICK_DIV);
    chk_state("rst.step", 2'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
